alu_seq: RTL and testbench

//   Parametrised, registered ALU; the WIDTH-generic successor of the 4-bit combinational ALU.

---
 rtl/alu_seq.sv | 190 +++++++++++++++++++
 tb/tb_alu_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-generic ALU with valid/ready handshake, a persistent {V,N,Z,C}
// flag register and multi-cycle shifts (one bit per cycle).
// Optional feature macro: ALU_MUL_EN enables the shift-add multiplier for opcode 1111.
// Without it, opcode 1111 completes in one cycle with f=0 and flags=4'b0010.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic [3:0]       flags
);

  localparam int unsigned SHW = $clog2(WIDTH);
  // Counter holds shift amounts (< 2**SHW) and WIDTH for the multiplier.
  localparam int unsigned CW  = SHW + 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_f;
  logic [3:0]       r_flags;

  logic [WIDTH-1:0] w_bp;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res1;
  logic             w_c1, w_v1;
  logic [3:0]       w_flg1;
  logic             w_is_shift, w_is_mul, w_go_busy;
  logic [WIDTH-1:0] w_sh_next, w_resb;
  logic             w_sh_out, w_cb;
  logic [3:0]       w_flgb;
  logic             w_accept, w_last;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] r_prod, r_mcand, w_prod_next;
  logic [WIDTH-1:0]   r_mplier;
  assign w_is_mul = (alu_ctrl == 4'b1111);
`else
  assign w_is_mul = 1'b0;
`endif

  assign w_is_shift = (alu_ctrl == 4'b1001) || (alu_ctrl == 4'b1011) || (alu_ctrl == 4'b1101);
  assign w_go_busy  = (w_is_shift && (b[SHW-1:0] != '0)) || w_is_mul;
  assign w_accept   = (r_state == StIdle) && in_valid;
  assign w_last     = (r_cnt == CW'(1));
  assign f          = r_f;
  assign flags      = r_flags;

  // Single-cycle result and flags computed straight from the presented operands.
  always_comb begin
    w_bp   = '0;
    w_sum  = '0;
    w_res1 = '0;
    w_c1   = 1'b0;
    w_v1   = 1'b0;
    unique case (alu_ctrl[2:1])
      2'b00:   w_bp = '0;
      2'b01:   w_bp = b;
      2'b10:   w_bp = ~b;
      default: w_bp = '1;
    endcase
    w_sum = {1'b0, a} + {1'b0, w_bp} + {{WIDTH{1'b0}}, alu_ctrl[0]};
    if (!alu_ctrl[3]) begin
      w_res1 = w_sum[WIDTH-1:0];
      // 0111 is a plain transfer: the wrap-around carry is not reported.
      w_c1   = w_sum[WIDTH] & (alu_ctrl != 4'b0111);
      w_v1   = (a[WIDTH-1] == w_bp[WIDTH-1]) & (w_sum[WIDTH-1] != a[WIDTH-1]);
    end else begin
      case (alu_ctrl)
        4'b1000: w_res1 = a & b;
        4'b1010: w_res1 = a | b;
        4'b1100: w_res1 = a ^ b;
        4'b1110: w_res1 = ~a;
        4'b1111: w_res1 = '0;  // only reaches DONE directly when the multiplier is absent
        default: w_res1 = a;   // shift by zero
      endcase
    end
    w_flg1 = {w_v1, w_res1[WIDTH-1], (w_res1 == '0), w_c1};
  end

  // One iteration of the multi-cycle datapath and the result it yields on the last step.
  always_comb begin
    w_sh_next = r_acc;
    w_sh_out  = 1'b0;
    case (r_op)
      4'b1001: begin
        w_sh_next = {r_acc[WIDTH-2:0], 1'b0};
        w_sh_out  = r_acc[WIDTH-1];
      end
      4'b1011: begin
        w_sh_next = {1'b0, r_acc[WIDTH-1:1]};
        w_sh_out  = r_acc[0];
      end
      default: begin
        w_sh_next = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
        w_sh_out  = r_acc[0];
      end
    endcase
    w_resb = w_sh_next;
    w_cb   = w_sh_out;
`ifdef ALU_MUL_EN
    w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
    if (r_op == 4'b1111) begin
      w_resb = w_prod_next[WIDTH-1:0];
      w_cb   = |w_prod_next[2*WIDTH-1:WIDTH];
    end
`endif
    w_flgb = {1'b0, w_resb[WIDTH-1], (w_resb == '0), w_cb};
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_d = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) w_state_d = w_go_busy ? StBusy : StDone;
      end
      StBusy: begin
        if (w_last) w_state_d = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  // Operand capture, iteration and result/flag registers (written only on entry to DONE).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_f     <= '0;
      r_flags <= '0;
`ifdef ALU_MUL_EN
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
`endif
    end else if (w_accept) begin
      r_op  <= alu_ctrl;
      r_acc <= a;
      r_cnt <= w_is_mul ? CW'(WIDTH) : {1'b0, b[SHW-1:0]};
`ifdef ALU_MUL_EN
      r_prod   <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
`endif
      if (!w_go_busy) begin
        r_f     <= w_res1;
        r_flags <= w_flg1;
      end
    end else if (r_state == StBusy) begin
      r_acc <= w_sh_next;
      r_cnt <= r_cnt - CW'(1);
`ifdef ALU_MUL_EN
      r_prod   <= w_prod_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
`endif
      if (w_last) begin
        r_f     <= w_resb;
        r_flags <= w_flgb;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed vectors, randomized ops against a
// behavioural model, backpressure, back-to-back traffic and reset in the middle of an op.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] alu_ctrl;
  logic [7:0] a, b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] f;
  logic [3:0] flags;

  int checks = 0;
  int errors = 0;
  logic [7:0] prev_f;
  logic [3:0] prev_flags;

  alu_seq #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_ctrl (alu_ctrl),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .f        (f),
    .flags    (flags)
  );

  always #5 clk = ~clk;

  // Reference: result, {V,N,Z,C} and accept-to-valid latency from the opcode table.
  function automatic void model(input logic [3:0] c, input logic [7:0] ia, input logic [7:0] ib,
                                output logic [7:0] ef, output logic [3:0] efl, output int lat);
    int k, bp, s, sa, sb, ss;
    logic v, cy;
    k = int'(ib) % 8;
    lat = 1; v = 1'b0; cy = 1'b0; ef = 8'h00;
    if (c[3] == 1'b0) begin
      case (c[2:1])
        2'd0: bp = 0;
        2'd1: bp = int'(ib);
        2'd2: bp = 255 - int'(ib);
        default: bp = 255;
      endcase
      s  = int'(ia) + bp + int'(c[0]);
      ef = 8'(s);
      cy = (s > 255);
      sa = (ia > 127) ? int'(ia) - 256 : int'(ia);
      sb = (bp > 127) ? bp - 256 : bp;
      ss = sa + sb + int'(c[0]);
      v  = (ss > 127) || (ss < -128);
      if (c == 4'b0111) begin v = 1'b0; cy = 1'b0; end
    end else begin
      case (c)
        4'b1000: ef = ia & ib;
        4'b1010: ef = ia | ib;
        4'b1100: ef = ia ^ ib;
        4'b1110: ef = ~ia;
        4'b1001: begin
          ef = 8'(int'(ia) << k);
          cy = (k > 0) ? 1'((int'(ia) >> (8 - k)) & 1) : 1'b0;
          lat = k + 1;
        end
        4'b1011: begin
          ef = 8'(int'(ia) >> k);
          cy = (k > 0) ? 1'((int'(ia) >> (k - 1)) & 1) : 1'b0;
          lat = k + 1;
        end
        4'b1101: begin
          sa = (ia > 127) ? int'(ia) - 256 : int'(ia);
          ef = 8'(sa >>> k);
          cy = (k > 0) ? 1'((int'(ia) >> (k - 1)) & 1) : 1'b0;
          lat = k + 1;
        end
        default: begin
`ifdef ALU_MUL_EN
          s = int'(ia) * int'(ib);
          ef = 8'(s);
          cy = (s > 255);
          lat = 9;
`else
          ef = 8'h00;
`endif
        end
      endcase
    end
    efl = {v, ef[7], (ef == 8'h00), cy};
  endfunction

  // Issue one op from IDLE, scramble inputs while it runs, check result and latency, retire it.
  task automatic run_op(input logic [3:0] c, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [7:0] ef, input logic [3:0] efl, input int elat,
                        input bit eager, input string name);
    int cyc;
    bit held;
    cyc = 0;
    while (!in_ready && cyc < 20) begin @(negedge clk); cyc++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready: got %b want 1", name, in_ready);
    end
    alu_ctrl = c; a = ia; b = ib; in_valid = 1'b1; out_ready = eager;
    @(negedge clk);
    alu_ctrl = 4'($urandom); a = 8'($urandom); b = 8'($urandom); in_valid = 1'($urandom);
    cyc = 1; held = 1'b1;
    while (!out_valid && cyc < 40) begin
      if (f !== prev_f || flags !== prev_flags) held = 1'b0;
      @(negedge clk);
      cyc++;
      alu_ctrl = 4'($urandom); a = 8'($urandom); b = 8'($urandom); in_valid = 1'($urandom);
    end
    in_valid = 1'b0;
    checks++;
    if (cyc !== elat || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: got %0d (out_valid=%b) want %0d", name, cyc, out_valid, elat);
    end
    checks++;
    if (f !== ef) begin
      errors++;
      $display("FAIL %s f: got %h want %h", name, f, ef);
    end
    checks++;
    if (flags !== efl) begin
      errors++;
      $display("FAIL %s flags: got %b want %b", name, flags, efl);
    end
    if (elat > 1) begin
      checks++;
      if (!held) begin
        errors++;
        $display("FAIL %s busy hold: f/flags changed before completion, want %h/%b",
                 name, prev_f, prev_flags);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s retire: got out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    end
    prev_f = ef;
    prev_flags = efl;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; alu_ctrl = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || f !== 8'h00 || flags !== 4'h0) begin
      errors++;
      $display("FAIL reset state: got out_valid=%b f=%h flags=%b want 0/00/0000",
               out_valid, f, flags);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset in_ready: got %b want 1", in_ready);
    end
    prev_f = 8'h00;
    prev_flags = 4'h0;
  endtask

  task automatic test_directed();
    run_op(4'b0010, 8'h7F, 8'h01, 8'h80, 4'b1100, 1, 1'b0, "add_ovf");
    run_op(4'b0101, 8'h05, 8'h05, 8'h00, 4'b0011, 1, 1'b0, "sub_zero");
    run_op(4'b0101, 8'h00, 8'h01, 8'hFF, 4'b0100, 1, 1'b0, "sub_borrow");
    run_op(4'b0001, 8'hFF, 8'h33, 8'h00, 4'b0011, 1, 1'b0, "inc_wrap");
    run_op(4'b0110, 8'h00, 8'h5A, 8'hFF, 4'b0100, 1, 1'b0, "dec_zero");
    run_op(4'b0111, 8'hFF, 8'h12, 8'hFF, 4'b0100, 1, 1'b0, "xfer_noflags");
    run_op(4'b1001, 8'h81, 8'h01, 8'h02, 4'b0001, 2, 1'b0, "shl1");
    run_op(4'b1101, 8'h80, 8'h07, 8'hFF, 4'b0100, 8, 1'b0, "asr7");
    run_op(4'b1011, 8'hC3, 8'h00, 8'hC3, 4'b0100, 1, 1'b0, "shr0");
`ifdef ALU_MUL_EN
    run_op(4'b1111, 8'h0C, 8'h0B, 8'h84, 4'b0100, 9, 1'b0, "mul_0c_0b");
    run_op(4'b1111, 8'h10, 8'h10, 8'h00, 4'b0011, 9, 1'b0, "mul_ovf");
`else
    run_op(4'b1111, 8'h0C, 8'h0B, 8'h00, 4'b0010, 1, 1'b0, "mul_absent");
`endif
  endtask

  task automatic test_random(input int n, input bit eager, input bool_arith_only);
    logic [3:0] c;
    logic [7:0] ia, ib, ef;
    logic [3:0] efl;
    int lat;
    for (int i = 0; i < n; i++) begin
      c  = 4'($urandom);
      if (bool_arith_only) c[3] = 1'b0;
      ia = 8'($urandom);
      ib = 8'($urandom);
      model(c, ia, ib, ef, efl, lat);
      run_op(c, ia, ib, ef, efl, lat, eager, eager ? "b2b" : "random");
    end
  endtask

  task automatic test_backpressure();
    alu_ctrl = 4'b0010; a = 8'h12; b = 8'h34; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || f !== 8'h46 || flags !== 4'b0000) begin
        errors++;
        $display("FAIL backpressure cycle %0d: got v=%b rdy=%b f=%h fl=%b want 1/0/46/0000",
                 i, out_valid, in_ready, f, flags);
      end
      alu_ctrl = 4'($urandom); a = 8'($urandom); b = 8'($urandom); in_valid = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || f !== 8'h46) begin
      errors++;
      $display("FAIL backpressure release: got v=%b rdy=%b f=%h want 0/1/46",
               out_valid, in_ready, f);
    end
    prev_f = 8'h46;
    prev_flags = 4'b0000;
  endtask

  task automatic test_reset_mid_op();
    run_op(4'b0010, 8'h7F, 8'h01, 8'h80, 4'b1100, 1, 1'b0, "pre_reset");
`ifdef ALU_MUL_EN
    alu_ctrl = 4'b1111; a = 8'h0C; b = 8'h0B;
`else
    alu_ctrl = 4'b1101; a = 8'h80; b = 8'h07;
`endif
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midop busy: got out_valid=%b in_ready=%b want 0/0", out_valid, in_ready);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || f !== 8'h00 || flags !== 4'h0) begin
      errors++;
      $display("FAIL midop reset: got out_valid=%b f=%h flags=%b want 0/00/0000",
               out_valid, f, flags);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midop release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    prev_f = 8'h00;
    prev_flags = 4'h0;
    run_op(4'b0010, 8'h01, 8'h01, 8'h02, 4'b0000, 1, 1'b0, "post_reset_add");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random(60, 1'b0, 1'b0);
    test_random(12, 1'b1, 1'b1);
    test_backpressure();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
